seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multi-cycle shift unit for the datapath. Shifts a 16-bit operand by a 4-bit amount (0-15).
- Uses the same 2-bit shift-op encoding as the single-step datapath shifter: 00 pass, 01 LSL, 10 LSR, 11 ASR.
- Applies one single-bit shift per clock under a start/busy/done handshake.
- Sits beside the ALU and serves multi-bit shift instructions that the single-step shifter cannot express.

Parameters:
- WIDTH, 16, operand/result width.
- AMT_W, 4, shift-amount width; maximum shift is 2**AMT_W-1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- in  input  WIDTH  operand, captured when start is accepted.
- shift  input  2  op code: 00 pass, 01 LSL, 10 LSR, 11 ASR.
- amount  input  AMT_W  number of bit positions.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; sout valid from this cycle.
- sout  output  WIDTH  registered result, held until the next done.

Behaviour:
- Reset: synchronous and active-high. Reset forces state IDLE, busy=0, done=0, sout=0, and clears the internal data register and counter. Reset mid-operation abandons the operation with no done pulse; reset has priority over start.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasting exactly one cycle.
- Acceptance: start is accepted in IDLE or DONE, so back-to-back operations are allowed. On acceptance, latch in, shift and amount:
  - If amount==0 or shift==00, go to DONE and load sout=in.
  - Otherwise go to RUN with cnt=amount.
- RUN, each cycle:
  - data <= op(data) and cnt <= cnt-1.
  - If cnt==1 on that edge, load sout with the shifted value and go to DONE.
- DONE with no start: go to IDLE. sout holds its value.
- Per-bit ops:
  - LSL: data<<1, zero fill at bit 0.
  - LSR: data>>1, zero fill at bit 15.
  - ASR: data>>1 with bit 15 replicated (sign preserved).
  - No rotate. Bits shifted out are discarded.
- Latency: with start high in cycle 0, done is high in cycle amount+1 (cycle 1 when amount==0 or op is pass). busy is high in cycles 1..amount for nonzero operations.
- start while busy (RUN) is ignored: no queueing, and the operands in flight are unaffected. Input changes during RUN have no effect.
- sout changes only on the edge that enters DONE, or on reset. It is stable during RUN and IDLE.
- Maximum amount 15 fully shifts out:
  - LSL 0x0001 by 15 gives 0x8000.
  - LSR 0x8000 by 15 gives 0x0001.
  - ASR 0x8000 by 15 gives 0xFFFF.
- done and busy are never high together.

Test Plan:
1. Reset, then start with in=0x00F0, shift=01, amount=4 -> busy high for cycles 1-4, done in cycle 5 only, sout=0x0F00 held afterward.
2. start with in=0x8001, shift=11, amount=15 -> done in cycle 16, sout=0xFFFF. Repeat with shift=10 -> sout=0x0001.
3. start with in=0x1234, amount=0, shift=01; then shift=00, amount=7 -> each gives done in cycle 1 with sout=0x1234 and busy never high.
4. start with in=0x0003, shift=01, amount=3, then pulse start again with in=0xFFFF during RUN -> second start ignored, sout=0x0018. A new start asserted in the done cycle is accepted: 0x0018 LSR 2 gives 0x0006 after 3 more cycles.
5. Start ASR of 0xC000 by 8 and assert reset in cycle 4 -> next cycle busy=0, done=0, sout=0; no done pulse appears; a fresh start then behaves normally.
6. Random sweep of all ops, amounts 0-15 and random operands against a reference model -> sout matches, latency equals amount+1, done is a single pulse, and busy and done are never both high.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle 16-bit shift unit that applies one single-bit shift
// per clock under a start/busy/done handshake.
// Op encoding on shift: 00 pass, 01 LSL, 10 LSR, 11 ASR. No rotate.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous active-high reset, priority over start
//   start  - request, accepted only in IDLE or DONE
//   in     - operand, captured when start is accepted
//   shift  - 2-bit op code
//   amount - shift distance 0 .. 2**AMT_W-1
//   busy   - high while a shift is running
//   done   - one-cycle pulse, sout valid from this cycle
//   sout   - registered result, held until the next done
module seq_shifter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sout
);

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_LSL  = 2'b01;
    localparam logic [1:0] OP_LSR  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [AMT_W-1:0]   cnt_q,   cnt_d;
    logic [1:0]         op_q,    op_d;
    logic [WIDTH-1:0]   sout_q,  sout_d;
    logic [WIDTH-1:0]   step_c;

    // One-bit shift of the in-flight operand; pass never reaches RUN.
    always_comb begin
        step_c = data_q;
        case (op_q)
            OP_LSL:  step_c = {data_q[WIDTH-2:0], 1'b0};
            OP_LSR:  step_c = {1'b0, data_q[WIDTH-1:1]};
            default: step_c = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_PASS;
            sout_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sout_q  <= sout_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sout_d  = sout_q;
        case (state_q)
            ST_RUN: begin
                data_d = step_c;
                cnt_d  = cnt_q - AMT_W'(1);
                // Last step: publish the shifted value on the edge entering DONE.
                if (cnt_q == AMT_W'(1)) begin
                    sout_d  = step_c;
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request (back-to-back allowed).
                if (start) begin
                    data_d = in;
                    op_d   = shift;
                    cnt_d  = amount;
                    if ((amount == '0) || (shift == OP_PASS)) begin
                        sout_d  = in;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign sout = sout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: stimulus pushes expected results,
// a monitor pops and compares whenever done is seen.
module tb_seq_shifter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AMT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] in_v;
    logic [1:0]       shift_v;
    logic [AMT_W-1:0] amount_v;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sout;

    seq_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (in_v),
        .shift  (shift_v),
        .amount (amount_v),
        .busy   (busy),
        .done   (done),
        .sout   (sout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] sout;
        int               issue;
        int               lat;
        int               nbusy;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [WIDTH-1:0] ref_shift(logic [WIDTH-1:0] v, logic [1:0] op, int amt);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        case (op)
            2'b01:   return WIDTH'(v << amt);
            2'b10:   return WIDTH'(v >> amt);
            2'b11:   return WIDTH'(s >>> amt);
            default: return v;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one accepted request and record what it must produce.
    task automatic issue(logic [WIDTH-1:0] v, logic [1:0] op, logic [AMT_W-1:0] amt);
        exp_t e;
        in_v     = v;
        shift_v  = op;
        amount_v = amt;
        start    = 1'b1;
        e.sout   = ref_shift(v, op, int'(amt));
        e.issue  = cyc;
        e.lat    = (amt == 0 || op == 2'b00) ? 1 : int'(amt) + 1;
        e.nbusy  = e.lat - 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        // Scramble inputs while the operation runs; they must have no effect.
        in_v     = WIDTH'($urandom);
        shift_v  = 2'($urandom);
        amount_v = AMT_W'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_v     = '0;
        shift_v  = '0;
        amount_v = '0;

        fork
            // Monitor: pop and compare on each done, watch invariants every cycle.
            begin : monitor
                exp_t             e;
                int               busy_run = 0;
                bit               rst_pend = 1'b0;
                logic [WIDTH-1:0] prev     = '0;
                forever begin
                    @(negedge clk);
                    if (reset) begin
                        rst_pend = 1'b1;
                        busy_run = 0;
                    end else begin
                        chk("busy_and_done", 32'(busy & done), 32'(0));
                        if (busy) busy_run++;
                        if (done) begin
                            if (sb.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_done: done=1 with nothing pending (cycle %0d)", cyc);
                            end else begin
                                e = sb.pop_front();
                                chk("sout", 32'(sout), 32'(e.sout));
                                chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                                chk("busy_cycles", 32'(busy_run), 32'(e.nbusy));
                            end
                            busy_run = 0;
                        end else if (!rst_pend) begin
                            chk("sout_hold", 32'(sout), 32'(prev));
                        end
                        rst_pend = 1'b0;
                    end
                    prev = sout;
                end
            end
        join_none

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_sout", 32'(sout), 32'(0));

        // 1: LSL 0x00F0 by 4, result held afterward.
        next_cycle();
        issue(16'h00F0, 2'b01, 4'd4);
        wait_done();
        repeat (3) @(negedge clk);
        chk("t1_hold", 32'(sout), 32'h0F00);

        // 2: full-width ASR and LSR by 15.
        next_cycle();
        issue(16'h8001, 2'b11, 4'd15);
        wait_done();
        next_cycle();
        issue(16'h8001, 2'b10, 4'd15);
        wait_done();

        // 3: zero amount and pass op complete in one cycle.
        next_cycle();
        issue(16'h1234, 2'b01, 4'd0);
        wait_done();
        next_cycle();
        issue(16'h1234, 2'b00, 4'd7);
        wait_done();

        // 4: start during RUN ignored, start in done cycle accepted.
        next_cycle();
        issue(16'h0003, 2'b01, 4'd3);
        next_cycle();
        start    = 1'b1;
        in_v     = 16'hFFFF;
        shift_v  = 2'b01;
        amount_v = 4'd1;
        next_cycle();
        start    = 1'b0;
        wait_done();
        chk("t4_first", 32'(sout), 32'h0018);
        issue(16'h0018, 2'b10, 4'd2);
        wait_done();
        chk("t4_second", 32'(sout), 32'h0006);

        // 5: reset mid-operation abandons it with no done.
        next_cycle();
        issue(16'hC000, 2'b11, 4'd8);
        repeat (3) next_cycle();
        reset = 1'b1;
        sb.delete();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_done", 32'(done), 32'(0));
        chk("t5_sout", 32'(sout), 32'(0));
        repeat (12) @(negedge clk);
        next_cycle();
        issue(16'hC000, 2'b11, 4'd8);
        wait_done();
        chk("t5_fresh", 32'(sout), 32'hFFC0);

        // 6: random sweep, half of the requests issued back-to-back in the done cycle.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0) next_cycle();
            issue(WIDTH'($urandom), 2'($urandom), AMT_W'($urandom));
            wait_done();
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
